// File: rtl/pacman_pkg.sv
// Shared types and default game constants for the game sequencer slice.
// The state encoding is visible on the sequencer's state output.
package pacman_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SPAWN     = 3'd1,
    S_PLAY      = 3'd2,
    S_DEATH     = 3'd3,
    S_GAME_OVER = 3'd4,
    S_WIN       = 3'd5
  } game_state_t;

  localparam int DEF_LIVES        = 3;
  localparam int DEF_SPAWN_FRAMES = 60;
  localparam int DEF_DEATH_FRAMES = 90;
  localparam int DEF_NUM_COINS    = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Control/status bundle between the game sequencer and the rest of the game.
// The master side drives the game events and the slave side is the sequencer.
interface game_sequencer_if #(
  parameter int NUM_COINS = pacman_pkg::DEF_NUM_COINS
);
  import pacman_pkg::*;

  logic                 start;
  logic                 frame_start;
  logic                 move_tick;
  logic                 kill_pac;
  logic [NUM_COINS-1:0] coin_visible;
  game_state_t          state;
  logic                 move_en;
  logic                 entity_reset;
  logic                 coin_reset;
  logic [1:0]           lives;
  logic [7:0]           score;

  modport master (
    output start, frame_start, move_tick, kill_pac, coin_visible,
    input  state, move_en, entity_reset, coin_reset, lives, score
  );

  modport slave (
    input  start, frame_start, move_tick, kill_pac, coin_visible,
    output state, move_en, entity_reset, coin_reset, lives, score
  );

endinterface

// File: rtl/frame_timer.sv
// Counts frame_start pulses and fires done on the pulse that reaches the
// terminal count; the sequencer shares it between SPAWN and DEATH.
module frame_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          frame_start_i,
  input  logic [CW-1:0] terminal_i,
  output logic          done_o
);

  logic [CW-1:0] cnt_q;

  assign done_o = !clear_i && frame_start_i && (cnt_q == terminal_i - CW'(1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, whatever the order the always blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear_i || done_o) begin
      cnt_q <= '0;
    end else if (frame_start_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Top-level game flow FSM: IDLE -> SPAWN -> PLAY -> DEATH/WIN -> GAME_OVER,
// with lives, saturating score and the entity/coin reset strobes.
module game_sequencer #(
  parameter int LIVES        = pacman_pkg::DEF_LIVES,
  parameter int SPAWN_FRAMES = pacman_pkg::DEF_SPAWN_FRAMES,
  parameter int DEATH_FRAMES = pacman_pkg::DEF_DEATH_FRAMES,
  parameter int NUM_COINS    = pacman_pkg::DEF_NUM_COINS
) (
  input  logic             clk,
  input  logic             reset,
  game_sequencer_if.slave  bus
);
  import pacman_pkg::*;

  localparam int CW = $clog2(max_int(SPAWN_FRAMES, DEATH_FRAMES) + 1);

  logic [1:0]           rst_sync_q;
  logic                 rst_n;
  game_state_t          state_q;
  logic [1:0]           lives_q;
  logic [7:0]           score_q;
  logic [7:0]           score_d;
  logic [8:0]           score_sum;
  logic                 start_q;
  logic [NUM_COINS-1:0] coin_q;
  logic                 entity_reset_q;
  logic                 coin_reset_q;
  logic                 start_rise;
  logic                 timer_clear;
  logic                 timer_done;
  logic [CW-1:0]        timer_term;

  // NOTE: reset asserts asynchronously but is released only after two clock
  // edges, so no register leaves reset on a metastable or partial edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign start_rise  = bus.start & ~start_q;
  assign timer_clear = !(state_q == S_SPAWN || state_q == S_DEATH);
  assign timer_term  = (state_q == S_SPAWN) ? CW'(SPAWN_FRAMES) : CW'(DEATH_FRAMES);

  frame_timer #(.CW(CW)) u_frame_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (timer_clear),
    .frame_start_i(bus.frame_start),
    .terminal_i   (timer_term),
    .done_o       (timer_done)
  );

  // Coins that vanished since last cycle are the ones pacman just ate.
  always_comb begin
    score_sum = {1'b0, score_q} + 9'($countones(coin_q & ~bus.coin_visible));
    score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      lives_q        <= 2'd0;
      score_q        <= 8'd0;
      start_q        <= 1'b1;
      coin_q         <= '1;
      entity_reset_q <= 1'b1;
      coin_reset_q   <= 1'b1;
    end else begin
      start_q <= bus.start;
      coin_q  <= bus.coin_visible;
      unique case (state_q)
        S_IDLE, S_GAME_OVER, S_WIN: begin
          if (start_rise) begin
            state_q        <= S_SPAWN;
            lives_q        <= 2'(LIVES);
            score_q        <= 8'd0;
            entity_reset_q <= 1'b1;
            coin_reset_q   <= 1'b1;
          end
        end
        S_SPAWN: begin
          if (timer_done) begin
            state_q        <= S_PLAY;
            entity_reset_q <= 1'b0;
            coin_reset_q   <= 1'b0;
          end
        end
        S_PLAY: begin
          score_q <= score_d;
          // Clearing the last coin beats a simultaneous kill.
          if (bus.coin_visible == '0) begin
            state_q <= S_WIN;
          end else if (bus.kill_pac) begin
            state_q <= S_DEATH;
            if (lives_q != 2'd0) lives_q <= lives_q - 2'd1;
          end
        end
        S_DEATH: begin
          if (timer_done) begin
            if (lives_q == 2'd0) begin
              state_q <= S_GAME_OVER;
            end else begin
              state_q        <= S_SPAWN;
              entity_reset_q <= 1'b1;
              coin_reset_q   <= 1'b0;
            end
          end
        end
        default: begin
          state_q        <= S_IDLE;
          entity_reset_q <= 1'b1;
          coin_reset_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.state        = state_q;
  assign bus.move_en      = bus.move_tick & (state_q == S_PLAY);
  assign bus.entity_reset = entity_reset_q;
  assign bus.coin_reset   = coin_reset_q;
  assign bus.lives        = lives_q;
  assign bus.score        = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a rule-level reference model that is
// compared against every output on each falling clock edge.
module tb_game_sequencer;
  import pacman_pkg::*;

  localparam int NC = 4;
  localparam int LV = 3;
  localparam int SF = 2;
  localparam int DF = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  game_sequencer_if #(.NUM_COINS(NC)) bus ();

  game_sequencer #(
    .LIVES(LV), .SPAWN_FRAMES(SF), .DEATH_FRAMES(DF), .NUM_COINS(NC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase numbers follow the visible state codes, frames are
  // counted as plain pulse tallies, release of reset takes two clock edges.
  int         m_state, m_lives, m_score, m_frames, m_release;
  bit         m_start_q, m_fresh_coins;
  logic [3:0] m_cv_q, m_lost;

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_state = 0; m_lives = 0; m_score = 0; m_frames = 0; m_release = 0;
        m_start_q = 1'b1; m_cv_q = 4'hF; m_fresh_coins = 1'b1;
      end else if (m_release < 2) begin
        m_release++;
      end else begin
        m_lost = m_cv_q & ~bus.coin_visible;
        case (m_state)
          0, 4, 5: if (bus.start && !m_start_q) begin
            m_state = 1; m_lives = LV; m_score = 0; m_frames = 0; m_fresh_coins = 1'b1;
          end
          1: if (bus.frame_start) begin
            m_frames++;
            if (m_frames == SF) begin m_state = 2; m_frames = 0; end
          end
          2: begin
            m_score = m_score + $countones(m_lost);
            if (m_score > 255) m_score = 255;
            if (bus.coin_visible == 4'h0) m_state = 5;
            else if (bus.kill_pac) begin
              m_state = 3; m_frames = 0;
              if (m_lives > 0) m_lives--;
            end
          end
          3: if (bus.frame_start) begin
            m_frames++;
            if (m_frames == DF) begin
              m_frames = 0;
              if (m_lives == 0) m_state = 4;
              else begin m_state = 1; m_fresh_coins = 1'b0; end
            end
          end
          default: m_state = 0;
        endcase
        m_start_q = bus.start;
        m_cv_q    = bus.coin_visible;
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_state",  int'(bus.state),        m_state);
    check("cmp_lives",  int'(bus.lives),        m_lives);
    check("cmp_score",  int'(bus.score),        m_score);
    check("cmp_move",   int'(bus.move_en),      int'(m_state == 2 && bus.move_tick));
    check("cmp_entity", int'(bus.entity_reset), int'(m_state == 0 || m_state == 1));
    check("cmp_coin",   int'(bus.coin_reset),   int'(m_state == 0 || (m_state == 1 && m_fresh_coins)));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
      tick();
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.frame_start = 1'b0; bus.move_tick = 1'b0;
    bus.kill_pac = 1'b0; bus.coin_visible = 4'hF;

    repeat (3) tick();
    check("rst_state", int'(bus.state), 0);
    check("rst_lives", int'(bus.lives), 0);
    check("rst_score", int'(bus.score), 0);
    check("rst_entity", int'(bus.entity_reset), 1);
    check("rst_coin", int'(bus.coin_reset), 1);
    bus.move_tick = 1'b1; #1;
    check("rst_move", int'(bus.move_en), 0);
    bus.move_tick = 1'b0;

    reset = 1'b1;
    repeat (4) tick();
    check("idle_after_release", int'(bus.state), 0);

    pulse_start();
    check("spawn_state", int'(bus.state), 1);
    check("spawn_lives", int'(bus.lives), 3);
    check("spawn_coin_reset", int'(bus.coin_reset), 1);
    frames(SF);
    check("play_state", int'(bus.state), 2);
    bus.move_tick = 1'b1; #1;
    check("play_move_same_cycle", int'(bus.move_en), 1);
    tick();
    bus.move_tick = 1'b0;
    pulse_start();
    check("start_in_play_ignored", int'(bus.state), 2);

    bus.coin_visible = 4'b1010; tick();
    check("score_two", int'(bus.score), 2);
    bus.coin_visible = 4'b0000; tick();
    check("win_state", int'(bus.state), 5);
    check("win_score", int'(bus.score), 4);
    bus.move_tick = 1'b1; #1;
    check("win_move", int'(bus.move_en), 0);
    tick();
    bus.move_tick = 1'b0;

    bus.coin_visible = 4'hF;
    pulse_start();
    check("restart_score", int'(bus.score), 0);
    frames(SF);
    for (int i = 0; i < 3; i++) begin
      bus.kill_pac = 1'b1; tick(); bus.kill_pac = 1'b0;
      check("death_state", int'(bus.state), 3);
      check("death_lives", int'(bus.lives), 2 - i);
      if (i == 0) begin
        pulse_start();
        check("start_in_death_ignored", int'(bus.state), 3);
      end
      frames(DF);
      if (i < 2) begin
        check("respawn_state", int'(bus.state), 1);
        check("respawn_no_coin_reset", int'(bus.coin_reset), 0);
        frames(SF);
        check("respawn_play", int'(bus.state), 2);
      end else begin
        check("game_over_state", int'(bus.state), 4);
        check("game_over_lives", int'(bus.lives), 0);
      end
    end

    pulse_start();
    check("go_restart_state", int'(bus.state), 1);
    check("go_restart_lives", int'(bus.lives), 3);
    check("go_restart_coin_reset", int'(bus.coin_reset), 1);
    frames(SF);
    bus.coin_visible = 4'b0001; tick();
    check("score_three", int'(bus.score), 3);
    bus.kill_pac = 1'b1; bus.coin_visible = 4'b0000; tick(); bus.kill_pac = 1'b0;
    check("kill_vs_win_state", int'(bus.state), 5);
    check("kill_vs_win_lives", int'(bus.lives), 3);

    bus.coin_visible = 4'hF;
    pulse_start();
    frames(SF);
    repeat (90) begin
      bus.coin_visible = 4'b0001; tick();
      bus.coin_visible = 4'hF;    tick();
    end
    check("score_saturated", int'(bus.score), 255);
    check("sat_still_play", int'(bus.state), 2);

    reset = 1'b0; #1;
    check("async_reset_state", int'(bus.state), 0);
    check("async_reset_score", int'(bus.score), 0);
    bus.start = 1'b1;
    tick(); tick();
    reset = 1'b1;
    repeat (5) tick();
    check("held_start_idle", int'(bus.state), 0);
    bus.start = 1'b0; tick();
    pulse_start();
    check("fresh_start_spawn", int'(bus.state), 1);

    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
